// File: rtl/rv32_pipeline_pkg.sv
// Shared pipeline records, MEM-stage FSM states, funct3 codes and lane helpers.
// RV32_MISALIGN_TRAP_EN selects misaligned-access trapping in the MEM stage.
package rv32_pipeline_pkg;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] alu_result;
    logic [31:0] mem_store_value;
    logic [4:0]  rd;
    logic        regFile_we;
    logic        mem_read;
    logic        mem_write;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] reg_store_value;
    logic        regFile_we;
    logic [4:0]  rd;
    logic [31:0] instruction;
  } mem_wb_t;

  typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Effective byte lane: offset bits below the access size are dropped.
  function automatic logic [1:0] lane_off(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return off;
      2'b01:   return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv32_load_align.sv
// Load data lane extraction and sign/zero extension.
module rv32_load_align
  import rv32_pipeline_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [1:0]  lo;
  logic [31:0] shifted;

  always_comb begin
    lo      = lane_off(funct3_i, off_i);
    shifted = rdata_i >> {lo, 3'b000};
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data_o = {24'd0, shifted[7:0]};
      F3_HU:   data_o = {16'd0, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/rv32_mem_stage.sv
// RV32 MEM stage: pass-through for ALU ops, req/gnt/rvalid handshake for loads/stores.
// Define RV32_MISALIGN_TRAP_EN to retire misaligned accesses without a memory request.
module rv32_mem_stage
  import rv32_pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  ex_mem_t     ex_mem_i,
  input  logic        ex_mem_valid_i,
  output logic        mem_ready_o,
  output mem_wb_t     mem_wb_o,
  output logic        mem_wb_valid_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        misaligned_o
);

  mem_state_t  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic        rfwe_q, rfwe_d;
  logic [31:0] instr_q, instr_d;
  mem_wb_t     mem_wb_q, mem_wb_d;
  logic        wb_vld_q, wb_vld_d;

  logic        accept, is_mem, mis_now;
  logic [2:0]  ex_f3;
  logic [1:0]  ex_off, ex_lo;
  logic [31:0] load_data;

  assign ex_f3  = ex_mem_i.instruction[14:12];
  assign ex_off = ex_mem_i.alu_result[1:0];
  assign ex_lo  = lane_off(ex_f3, ex_off);
  assign is_mem = ex_mem_i.mem_read | ex_mem_i.mem_write;
  assign accept = ex_mem_valid_i & mem_ready_o;

`ifdef RV32_MISALIGN_TRAP_EN
  assign mis_now = is_mem & is_misaligned(ex_f3, ex_off);
`else
  assign mis_now = 1'b0;
`endif

  rv32_load_align u_load_align (
    .rdata_i  (dmem_rdata_i),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (load_data)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    we_d     = we_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    rfwe_d   = rfwe_q;
    instr_d  = instr_q;
    mem_wb_d = mem_wb_q;
    wb_vld_d = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (is_mem && !mis_now) begin
          addr_d  = ex_mem_i.alu_result;
          wdata_d = ex_mem_i.mem_store_value << {ex_lo, 3'b000};
          be_d    = store_be(ex_f3, ex_lo);
          we_d    = ex_mem_i.mem_write;
          f3_d    = ex_f3;
          rd_d    = ex_mem_i.rd;
          rfwe_d  = ex_mem_i.regFile_we;
          instr_d = ex_mem_i.instruction;
          state_d = REQ;
        end else begin
          // ALU ops, and trapped misaligned accesses, retire straight from IDLE.
          mem_wb_d = '{reg_store_value: ex_mem_i.alu_result,
                       regFile_we:      ex_mem_i.regFile_we & ~mis_now,
                       rd:              ex_mem_i.rd,
                       instruction:     ex_mem_i.instruction};
          wb_vld_d = 1'b1;
        end
      end
      REQ: if (dmem_gnt_i) begin
        if (we_q) begin
          mem_wb_d = '{reg_store_value: addr_q, regFile_we: 1'b0,
                       rd: rd_q, instruction: instr_q};
          wb_vld_d = 1'b1;
          state_d  = IDLE;
        end else if (dmem_rvalid_i) begin
          mem_wb_d = '{reg_store_value: load_data, regFile_we: rfwe_q,
                       rd: rd_q, instruction: instr_q};
          wb_vld_d = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d  = RESP;
        end
      end
      RESP: if (dmem_rvalid_i) begin
        mem_wb_d = '{reg_store_value: load_data, regFile_we: rfwe_q,
                     rd: rd_q, instruction: instr_q};
        wb_vld_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      f3_q     <= '0;
      rd_q     <= '0;
      rfwe_q   <= 1'b0;
      instr_q  <= '0;
      mem_wb_q <= '0;
      wb_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      rfwe_q   <= rfwe_d;
      instr_q  <= instr_d;
      mem_wb_q <= mem_wb_d;
      wb_vld_q <= wb_vld_d;
    end
  end

`ifdef RV32_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  assign mis_d = (state_q == IDLE) & accept & mis_now;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end
  assign misaligned_o = mis_q;
`else
  assign misaligned_o = 1'b0;
`endif

  assign mem_ready_o    = (state_q == IDLE);
  assign dmem_req_o     = (state_q == REQ);
  assign dmem_we_o      = we_q;
  assign dmem_addr_o    = {addr_q[31:2], 2'b00};
  assign dmem_wdata_o   = wdata_q;
  assign dmem_be_o      = be_q;
  assign mem_wb_o       = mem_wb_q;
  assign mem_wb_valid_o = wb_vld_q;

endmodule
